// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// ---------------
// Round-robin arbiter that shares the single write port of an asynchronous
// FIFO, on its write side, among NREQ requesters. A winner keeps the port
// for up to BURST words, so each requester's data lands contiguously in the
// FIFO. The FIFO full flag back-pressures the current owner.
//
// Optional feature macro: FIFO_ARB_WORD_CNT_EN
//   When defined, adds the 32-bit output wr_words. It is a saturating count
//   of words written since reset.
//
// Ports:
//   clk_w       write-domain clock
//   rst_w       synchronous, active-low reset
//   req_valid   per-requester word available
//   req_data    requester i data on bits [i*width +: width]
//   req_ready   per-requester word accepted this cycle
//   full        FIFO full flag from the write pointer/full logic
//   wrt_enable  write request to the pointer logic and the memory
//   wdata       data for the FIFO memory write (zero when not writing)
//   owner       index of the current owner
//   busy        high while an ownership window is open
//   wr_words    (FIFO_ARB_WORD_CNT_EN only) words written since reset

module fifo_wr_arbiter #(
  parameter int width = 32,
  parameter int NREQ  = 4,
  parameter int BURST = 4,
  localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW   = $clog2(BURST) + 1
) (
  input  logic                  clk_w,
  input  logic                  rst_w,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*width-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  full,
  output logic                  wrt_enable,
  output logic [width-1:0]      wdata,
  output logic [OW-1:0]         owner,
  output logic                  busy
`ifdef FIFO_ARB_WORD_CNT_EN
  ,
  output logic [31:0]           wr_words
`endif
);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

  state_t        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] last_q,  last_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          busy_q,  busy_d;

  logic          found;
  logic [OW-1:0] pick;
  logic          in_burst;

  // Round-robin search starting one past the previous owner, wrapping at
  // NREQ (which need not be a power of two).
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(last_q) + 1 + i) % NREQ;
      if (!found && req_valid[OW'(idx)]) begin
        found = 1'b1;
        pick  = OW'(idx);
      end
    end
  end

  // Handshake is combinational so data passes straight through. It is
  // gated with rst_w so that no word is accepted on a reset edge, even
  // when the reset arrives mid-burst.
  always_comb begin
    in_burst   = (state_q == ST_BURST) && rst_w;
    req_ready  = '0;
    wrt_enable = 1'b0;
    wdata      = '0;
    if (in_burst && !full) begin
      req_ready  = NREQ'(1) << owner_q;
      wrt_enable = req_valid[owner_q];
    end
    if (wrt_enable) begin
      wdata = req_data[int'(owner_q)*width +: width];
    end
  end

  // Next-state logic. A full FIFO stalls the window without releasing it,
  // because full is global and no other requester could make progress.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          owner_d = pick;
          cnt_d   = '0;
          state_d = ST_BURST;
          busy_d  = 1'b1;
        end
      end
      ST_BURST: begin
        if (!full) begin
          if (req_valid[owner_q] && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            // Either the window is exhausted or the owner has released.
            state_d = ST_IDLE;
            last_d  = owner_q;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // last resets to NREQ-1 so that requester 0 has first priority.
  always_ff @(posedge clk_w) begin
    if (!rst_w) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= OW'(NREQ - 1);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign owner = owner_q;
  assign busy  = busy_q;

`ifdef FIFO_ARB_WORD_CNT_EN
  logic [31:0] wr_words_q, wr_words_d;

  // Saturating count of words written.
  always_comb begin
    wr_words_d = wr_words_q;
    if (wrt_enable && (wr_words_q != 32'hFFFF_FFFF)) begin
      wr_words_d = wr_words_q + 32'd1;
    end
  end

  always_ff @(posedge clk_w) begin
    if (!rst_w) begin
      wr_words_q <= '0;
    end else begin
      wr_words_q <= wr_words_d;
    end
  end

  assign wr_words = wr_words_q;
`endif

endmodule
